// File: rtl/dll_pkg.sv
// rtl/dll_pkg.sv - shared DLC state, DLLP type encodings and DLLP packing helpers
package dll_pkg;
  localparam int DLLP_W = 136;

  localparam logic [1:0] DLC_DL_INACTIVE = 2'b00;
  localparam logic [1:0] DLC_DL_INIT     = 2'b01;
  localparam logic [1:0] DLC_DL_ACTIVE   = 2'b11;

  localparam logic [7:0] DLLP_ACK       = 8'h00;
  localparam logic [7:0] DLLP_NAK       = 8'h10;
  localparam logic [7:0] DLLP_UPDFC_P   = 8'h80;
  localparam logic [7:0] DLLP_UPDFC_NP  = 8'h90;
  localparam logic [7:0] DLLP_UPDFC_CPL = 8'hA0;

  typedef enum logic [1:0] {FC_P = 2'd0, FC_NP = 2'd1, FC_CPL = 2'd2} fc_type_e;

  function automatic logic [DLLP_W-1:0] pack_updfc(input logic [7:0] type_b,
                                                   input logic [7:0] hdr,
                                                   input logic [11:0] data);
    return {type_b, 2'b00, hdr[7:2], hdr[1:0], 2'b00, data[11:8], data[7:0],
            {(DLLP_W-32){1'b0}}};
  endfunction

  function automatic logic [DLLP_W-1:0] pack_acknak(input logic nak, input logic [11:0] seq);
    return {(nak ? DLLP_NAK : DLLP_ACK), 8'h00, 4'h0, seq, {(DLLP_W-32){1'b0}}};
  endfunction
endpackage

// File: rtl/dll_rr_arb3.sv
// rtl/dll_rr_arb3.sv - 3-way round-robin arbiter, pointer moves past the winner on accept
module dll_rr_arb3
  import dll_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_i,
  input  logic       acc_i,
  input  logic [2:0] acc_gnt_i,
  output logic [2:0] gnt_o
);
  fc_type_e   ptr_q, ptr_d;
  logic [5:0] req_rot;
  logic [5:0] gnt_rot;
  logic [2:0] pick;

  always_comb begin
    ptr_d = ptr_q;
    if (acc_i) begin
      case (acc_gnt_i)
        3'b001:  ptr_d = FC_NP;
        3'b010:  ptr_d = FC_CPL;
        3'b100:  ptr_d = FC_P;
        default: ptr_d = ptr_q;
      endcase
    end
  end

  // Grant uses the post-accept pointer so a back-to-back load sees the rotated order.
  always_comb begin
    req_rot = {req_i, req_i} >> ptr_d;
    pick    = 3'b000;
    if (req_rot[0])      pick = 3'b001;
    else if (req_rot[1]) pick = 3'b010;
    else if (req_rot[2]) pick = 3'b100;
    gnt_rot = {pick, pick} << ptr_d;
    gnt_o   = gnt_rot[5:3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= FC_P;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/dll_tx_dllp_sched.sv
// rtl/dll_tx_dllp_sched.sv - TX DLLP scheduler: Ack/Nak priority over round-robin UpdateFC
module dll_tx_dllp_sched
  import dll_pkg::*;
#(
  parameter int VC_ID        = 0,
  parameter int UPDATE_TIMER = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        dlc_state_i,
  input  logic              acknak_req_i,
  input  logic              acknak_nak_i,
  input  logic [11:0]       acknak_seq_i,
  input  logic [7:0]        p_hdr_credit_i,
  input  logic [11:0]       p_data_credit_i,
  input  logic [7:0]        np_hdr_credit_i,
  input  logic [11:0]       np_data_credit_i,
  input  logic [7:0]        cpl_hdr_credit_i,
  input  logic [11:0]       cpl_data_credit_i,
  output logic [DLLP_W-1:0] dllp_o,
  output logic              dllp_valid_o,
  input  logic              dllp_ready_i
);
  localparam int            TW         = $clog2(UPDATE_TIMER);
  localparam logic [TW-1:0] TIMER_LAST = TW'(UPDATE_TIMER - 1);
  localparam logic [7:0]    VC_BITS    = {5'd0, 3'(VC_ID)};

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e            state_q, state_d;
  logic              active, active_q;
  logic [TW-1:0]     timer_q, timer_d;
  logic              an_pend_q, an_pend_d, an_nak_q, an_nak_d;
  logic [11:0]       an_seq_q, an_seq_d;
  logic [2:0]        fc_pend_q, fc_pend_d;
  logic [2:0][19:0]  cur_cred, last_q, last_d;
  logic [DLLP_W-1:0] dllp_q, dllp_d;
  logic              sent_an_q, sent_an_d;
  logic [2:0]        sent_fc_q, sent_fc_d;
  logic [19:0]       sent_cred_q, sent_cred_d;

  logic              accept, acc_an, acc_fc, timer_exp, an_take, rem_an, can_load;
  logic [2:0]        fc_clr, fc_set, rem_fc, gnt;
  logic [19:0]       win_cred;
  logic [7:0]        win_type;

  assign active      = (dlc_state_i == DLC_DL_ACTIVE);
  assign cur_cred[0] = {p_hdr_credit_i, p_data_credit_i};
  assign cur_cred[1] = {np_hdr_credit_i, np_data_credit_i};
  assign cur_cred[2] = {cpl_hdr_credit_i, cpl_data_credit_i};

  assign accept    = (state_q == ST_SEND) && active && dllp_ready_i;
  assign acc_an    = accept && sent_an_q;
  assign acc_fc    = accept && !sent_an_q;
  assign fc_clr    = acc_fc ? sent_fc_q : 3'b000;
  assign timer_exp = active && (timer_q == TIMER_LAST);
  assign rem_an    = an_pend_q && !acc_an;
  assign rem_fc    = fc_pend_q & ~fc_clr;
  assign can_load  = active && ((state_q == ST_IDLE) || accept) && (rem_an || (|rem_fc));

  dll_rr_arb3 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (rem_fc),
    .acc_i     (acc_fc),
    .acc_gnt_i (sent_fc_q),
    .gnt_o     (gnt)
  );

  // Change detection compares against the value that will be last-sent after this edge,
  // so a credit moving during SEND re-arms the flag while an unchanged one clears.
  always_comb begin
    timer_d = (active && !timer_exp) ? timer_q + 1'b1 : '0;
    last_d  = last_q;
    fc_set  = 3'b000;
    for (int t = 0; t < 3; t++) begin
      if (fc_clr[t]) last_d[t] = sent_cred_q;
      fc_set[t] = active && (!active_q || timer_exp || (cur_cred[t] != last_d[t]));
    end
    fc_pend_d = active ? (rem_fc | fc_set) : 3'b000;
    an_take   = active && acknak_req_i &&
                (acc_an || !(an_pend_q && an_nak_q && !acknak_nak_i));
    an_pend_d = active && (an_take || rem_an);
    an_nak_d  = an_take ? acknak_nak_i : an_nak_q;
    an_seq_d  = an_take ? acknak_seq_i : an_seq_q;
  end

  always_comb begin
    win_cred = cur_cred[0];
    win_type = DLLP_UPDFC_P;
    if (gnt[1]) begin
      win_cred = cur_cred[1];
      win_type = DLLP_UPDFC_NP;
    end else if (gnt[2]) begin
      win_cred = cur_cred[2];
      win_type = DLLP_UPDFC_CPL;
    end
  end

  always_comb begin
    state_d     = state_q;
    dllp_d      = dllp_q;
    sent_an_d   = sent_an_q;
    sent_fc_d   = sent_fc_q;
    sent_cred_d = sent_cred_q;
    if (!active) begin
      state_d = ST_IDLE;
    end else if (can_load) begin
      state_d = ST_SEND;
      if (rem_an) begin
        dllp_d    = pack_acknak(an_nak_q, an_seq_q);
        sent_an_d = 1'b1;
        sent_fc_d = 3'b000;
      end else begin
        dllp_d      = pack_updfc(win_type | VC_BITS, win_cred[19:12], win_cred[11:0]);
        sent_an_d   = 1'b0;
        sent_fc_d   = gnt;
        sent_cred_d = win_cred;
      end
    end else if (accept) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      active_q    <= 1'b0;
      timer_q     <= '0;
      an_pend_q   <= 1'b0;
      an_nak_q    <= 1'b0;
      an_seq_q    <= '0;
      fc_pend_q   <= 3'b000;
      last_q      <= '0;
      dllp_q      <= '0;
      sent_an_q   <= 1'b0;
      sent_fc_q   <= 3'b000;
      sent_cred_q <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active;
      timer_q     <= timer_d;
      an_pend_q   <= an_pend_d;
      an_nak_q    <= an_nak_d;
      an_seq_q    <= an_seq_d;
      fc_pend_q   <= fc_pend_d;
      last_q      <= last_d;
      dllp_q      <= dllp_d;
      sent_an_q   <= sent_an_d;
      sent_fc_q   <= sent_fc_d;
      sent_cred_q <= sent_cred_d;
    end
  end

  assign dllp_o       = dllp_q;
  assign dllp_valid_o = (state_q == ST_SEND);
endmodule

// File: tb/tb_dll_tx_dllp_sched.sv
// tb/tb_dll_tx_dllp_sched.sv - vector table, directed corner sequences, random run vs reference model
`timescale 1ns/1ps
module tb_dll_tx_dllp_sched;
  import dll_pkg::*;

  localparam int UT  = 16;
  localparam int VCN = 0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   dlc_state = DLC_DL_INACTIVE;
  logic         acknak_req = 1'b0, acknak_nak = 1'b0;
  logic [11:0]  acknak_seq = 12'h0;
  logic [7:0]   p_hdr = 8'h10, np_hdr = 8'h08, cpl_hdr = 8'h00;
  logic [11:0]  p_data = 12'h040, np_data = 12'h000, cpl_data = 12'h000;
  logic [135:0] dllp_o;
  logic         dllp_valid_o;
  logic         dllp_ready = 1'b1;

  always #5 clk = ~clk;

  dll_tx_dllp_sched #(.VC_ID(VCN), .UPDATE_TIMER(UT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dlc_state_i       (dlc_state),
    .acknak_req_i      (acknak_req),
    .acknak_nak_i      (acknak_nak),
    .acknak_seq_i      (acknak_seq),
    .p_hdr_credit_i    (p_hdr),
    .p_data_credit_i   (p_data),
    .np_hdr_credit_i   (np_hdr),
    .np_data_credit_i  (np_data),
    .cpl_hdr_credit_i  (cpl_hdr),
    .cpl_data_credit_i (cpl_data),
    .dllp_o            (dllp_o),
    .dllp_valid_o      (dllp_valid_o),
    .dllp_ready_i      (dllp_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_word(input string name, input logic [135:0] got, input logic [135:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: what the link layer has queued and what is on the wire.
  bit           m_valid;
  logic [135:0] m_dllp;
  int           m_kind;
  logic [19:0]  m_sent;
  bit           m_an_pend, m_an_nak;
  logic [11:0]  m_an_seq;
  bit   [2:0]   m_fc_pend;
  logic [19:0]  m_last [3];
  int           m_timer, m_rr;
  bit           m_prev_act;

  function automatic logic [19:0] cred_of(input int t);
    case (t)
      0:       return {p_hdr, p_data};
      1:       return {np_hdr, np_data};
      default: return {cpl_hdr, cpl_data};
    endcase
  endfunction

  function automatic logic [135:0] fc_word(input int t, input logic [19:0] c);
    int hdr, data;
    logic [7:0] b0, b1, b2, b3;
    hdr  = int'(c[19:12]);
    data = int'(c[11:0]);
    b0 = 8'(128 + 16 * t + VCN);
    b1 = 8'(hdr / 4);
    b2 = 8'((hdr % 4) * 64 + data / 256);
    b3 = 8'(data % 256);
    return {b0, b1, b2, b3, 104'd0};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_dllp = '0; m_kind = 0; m_sent = '0;
    m_an_pend = 0; m_an_nak = 0; m_an_seq = '0; m_fc_pend = '0;
    for (int t = 0; t < 3; t++) m_last[t] = '0;
    m_timer = 0; m_rr = 0; m_prev_act = 0;
  endtask

  task automatic model_edge();
    bit acc, snap_an;
    bit [2:0] snap_fc;
    int w;
    if (dlc_state != 2'b11) begin
      m_valid = 0; m_an_pend = 0; m_fc_pend = '0; m_timer = 0; m_prev_act = 0;
      return;
    end
    acc = m_valid && dllp_ready;
    if (acc) begin
      if (m_kind == 3) m_an_pend = 0;
      else begin
        m_fc_pend[m_kind] = 0;
        m_last[m_kind] = m_sent;
        m_rr = (m_kind + 1) % 3;
      end
      m_valid = 0;
    end
    snap_an = m_an_pend;
    snap_fc = m_fc_pend;
    if (!m_valid) begin
      if (snap_an) begin
        m_kind = 3; m_valid = 1;
        m_dllp = {(m_an_nak ? 8'h10 : 8'h00), 8'h00, 4'h0, m_an_seq, 104'd0};
      end else begin
        for (int k = 0; k < 3; k++) begin
          w = (m_rr + k) % 3;
          if (!m_valid && snap_fc[w]) begin
            m_kind = w; m_valid = 1;
            m_sent = cred_of(w);
            m_dllp = fc_word(w, m_sent);
          end
        end
      end
    end
    for (int t = 0; t < 3; t++)
      if (!m_prev_act || m_timer == UT - 1 || cred_of(t) != m_last[t]) m_fc_pend[t] = 1;
    if (acknak_req && !(m_an_pend && m_an_nak && !acknak_nak)) begin
      m_an_pend = 1; m_an_nak = acknak_nak; m_an_seq = acknak_seq;
    end
    m_timer = (m_timer == UT - 1) ? 0 : m_timer + 1;
    m_prev_act = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    @(negedge clk);
    check_bit("model_valid", dllp_valid_o, m_valid);
    check_word("model_dllp", dllp_o, m_dllp);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!dllp_valid_o && k < 40) begin
      tick();
      k++;
    end
    check_bit(name, dllp_valid_o, 1'b1);
  endtask

  typedef struct {
    logic [1:0]  dlc;
    logic        rdy;
    logic        req;
    logic        nak;
    logic [11:0] seq;
    logic [7:0]  nph;
    logic        ev;
    logic [31:0] ew;
  } vec_t;

  vec_t     tbl [14];
  int       rises [$];
  bit       prev_v;
  logic [2:0] seen;
  int       nv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 12'h000, 8'h08, 1'b0, 32'h0};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 12'h000, 8'h08, 1'b1, 32'h80040040};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 12'h000, 8'h08, 1'b1, 32'h90020000};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 1'b0, 12'h000, 8'h08, 1'b1, 32'hA0000000};
    tbl[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 12'h000, 8'h08, 1'b0, 32'h0};
    tbl[5]  = '{2'b11, 1'b0, 1'b1, 1'b0, 12'h123, 8'h0C, 1'b0, 32'h0};
    for (int i = 6; i < 12; i++)
      tbl[i] = '{2'b11, 1'b0, 1'b0, 1'b0, 12'h000, 8'h0C, 1'b1, 32'h00000123};
    tbl[12] = '{2'b11, 1'b1, 1'b0, 1'b0, 12'h000, 8'h0C, 1'b1, 32'h90030000};
    tbl[13] = '{2'b11, 1'b1, 1'b0, 1'b0, 12'h000, 8'h0C, 1'b0, 32'h0};

    model_reset();
    tick();
    check_bit("reset_valid", dllp_valid_o, 1'b0);
    check_word("reset_dllp", dllp_o, 136'd0);
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 14; i++) begin
      dlc_state  = tbl[i].dlc;
      dllp_ready = tbl[i].rdy;
      acknak_req = tbl[i].req;
      acknak_nak = tbl[i].nak;
      acknak_seq = tbl[i].seq;
      np_hdr     = tbl[i].nph;
      tick();
      check_bit($sformatf("vec%0d_valid", i), dllp_valid_o, tbl[i].ev);
      if (tbl[i].ev) check_word($sformatf("vec%0d_dllp", i), dllp_o, {tbl[i].ew, 104'd0});
    end
    acknak_req = 1'b0;

    // Ack/Nak/Ack collapse while a DLLP is stalled
    dllp_ready = 1'b0;
    p_hdr = 8'h14;
    wait_valid("collapse_stall_valid");
    acknak_req = 1'b1; acknak_nak = 1'b0; acknak_seq = 12'h010; tick();
    acknak_nak = 1'b1; acknak_seq = 12'h011; tick();
    acknak_nak = 1'b0; acknak_seq = 12'h012; tick();
    acknak_req = 1'b0;
    dllp_ready = 1'b1;
    tick();
    check_bit("collapse_valid", dllp_valid_o, 1'b1);
    check_word("collapse_nak", dllp_o, {32'h10000011, 104'd0});
    tick();
    check_bit("collapse_single", dllp_valid_o == 1'b1 && dllp_o[135:128] == 8'h00, 1'b0);

    // Periodic refresh with stable credits
    for (int i = 0; i < 8; i++) tick();
    prev_v = dllp_valid_o;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (dllp_valid_o && !prev_v) rises.push_back(i);
      prev_v = dllp_valid_o;
    end
    check_bit("timer_bursts_seen", rises.size() >= 3, 1'b1);
    if (rises.size() >= 3) begin
      check_int("timer_period_a", rises[1] - rises[0], UT);
      check_int("timer_period_b", rises[2] - rises[1], UT);
    end

    // Leave DL_Active mid-SEND, then re-enter
    dllp_ready = 1'b0;
    cpl_hdr = 8'h04;
    wait_valid("drop_stall_valid");
    dlc_state = DLC_DL_INIT;
    tick();
    check_bit("drop_valid0", dllp_valid_o, 1'b0);
    tick();
    check_bit("drop_valid1", dllp_valid_o, 1'b0);
    dlc_state = DLC_DL_ACTIVE;
    dllp_ready = 1'b1;
    seen = 3'b000;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dllp_valid_o) begin
        nv++;
        seen[int'(dllp_o[133:132])] = 1'b1;
      end
    end
    check_word("reentry_types", {133'd0, seen}, {133'd0, 3'b111});
    check_int("reentry_count", nv, 3);

    // Asynchronous reset while stalled
    dllp_ready = 1'b0;
    np_data = 12'h055;
    wait_valid("reset_stall_valid");
    rst_n = 1'b0;
    #1;
    check_bit("async_reset_valid", dllp_valid_o, 1'b0);
    check_word("async_reset_dllp", dllp_o, 136'd0);
    model_reset();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) dlc_state = 2'($urandom_range(0, 2));
      else if (dlc_state != DLC_DL_ACTIVE && $urandom_range(0, 7) == 0) dlc_state = DLC_DL_ACTIVE;
      dllp_ready = ($urandom_range(0, 9) < 7);
      acknak_req = ($urandom_range(0, 7) == 0);
      acknak_nak = ($urandom_range(0, 1) == 1);
      acknak_seq = 12'($urandom);
      if ($urandom_range(0, 31) == 0) p_hdr    = 8'($urandom);
      if ($urandom_range(0, 31) == 0) p_data   = 12'($urandom);
      if ($urandom_range(0, 31) == 0) np_hdr   = 8'($urandom);
      if ($urandom_range(0, 31) == 0) np_data  = 12'($urandom);
      if ($urandom_range(0, 31) == 0) cpl_hdr  = 8'($urandom);
      if ($urandom_range(0, 31) == 0) cpl_data = 12'($urandom);
      tick();
    end
    acknak_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dll_tx_dllp_sched.md
Name: dll_tx_dllp_sched

Overview:
Transmit-side DLLP scheduler for one VC in the data link layer.
- Arbitrates between Ack/Nak requests and UpdateFC requests for the Posted (P), Non-Posted (NP) and Completion (Cpl) credit types.
- Formats the winning DLLP and holds it on a valid/ready handshake toward the PHY framing stage.
- Generates UpdateFC on DL_Active entry, on any credit change, and on a periodic refresh timer.

Parameters:
VC_ID, 0, virtual channel number placed in UpdateFC byte 0 [2:0]
UPDATE_TIMER, 1024, clock cycles between forced UpdateFC refreshes of all three types (≥2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
dlc_state_i  input  2  DLCMSM state; 2'b11 = DL_Active
acknak_req_i  input  1  one-cycle pulse requesting an Ack/Nak DLLP
acknak_nak_i  input  1  qualifies acknak_req_i: 1 = Nak, 0 = Ack
acknak_seq_i  input  12  AckNak_Seq_Num, qualified by acknak_req_i
p_hdr_credit_i  input  8  local P header credits to advertise
p_data_credit_i  input  12  local P data credits
np_hdr_credit_i  input  8  NP header credits
np_data_credit_i  input  12  NP data credits
cpl_hdr_credit_i  input  8  Cpl header credits
cpl_data_credit_i  input  12  Cpl data credits
dllp_o  output  136  DLLP: bytes 0..3 at [135:104]; [103:0] zero (CRC is inserted downstream)
dllp_valid_o  output  1  dllp_o valid
dllp_ready_i  input  1  PHY accepts dllp_o when valid && ready

Behaviour:
- The clock is clk and the reset is rst_n: a single clock, with an asynchronous active-low reset.
- Reset values: dllp_o=0, dllp_valid_o=0, all pending flags=0, last-sent credits=0, timer=0, RR pointer=P, FSM=IDLE.
- Encoding, byte 0:
  - Ack = 8'h00, Nak = 8'h10.
  - UpdateFC-P = {4'h8,1'b0,VC_ID[2:0]}, NP = {4'h9,…}, Cpl = {4'hA,…}.
- Encoding, bytes 1-3:
  - UpdateFC: byte 1 = {2'b00,hdr[7:2]}; byte 2 = {hdr[1:0],2'b00,data[11:8]}; byte 3 = data[7:0].
  - Ack/Nak: byte 1 = 0; byte 2 = {4'h0,seq[11:8]}; byte 3 = seq[7:0].
- Ack/Nak pending register:
  - acknak_req_i sets the pending flag and captures type and seq.
  - A newer request overwrites an older pending one, except that an Ack never overwrites a pending Nak.
  - Requests are captured in any state, but are dropped while not DL_Active.
- UpdateFC pending flag per type is set when:
  - the rising edge into DL_Active occurs (all three), or
  - the type's {hdr,data} input differs from its last-sent value, or
  - the timer expires (all three).
- Timer:
  - Counts only while DL_Active.
  - At count UPDATE_TIMER-1 it expires and wraps to 0.
- FSM, two states:
  - IDLE: if DL_Active and any flag is pending, select a winner and load dllp_o on the same clock edge; go to SEND with dllp_valid_o=1 the next cycle. Latency from a pending flag set to valid = 1 cycle.
  - SEND: dllp_o and valid are held stable until dllp_ready_i.
  - On the accept edge, clear the winner's flag. For UpdateFC, also record the sent credits as last-sent.
  - After accept, return to IDLE, or chain directly into the next pending DLLP with no bubble.
- Arbitration:
  - Ack/Nak has strict priority over UpdateFC.
  - Among UpdateFC types, round-robin; the pointer advances to winner+1 only on accept.
- Credits are sampled at load time.
  - A credit change during SEND re-sets that type's pending flag after accept, so the newer value is sent next.
- Simultaneous events:
  - A pending set on the same edge as a clear of the same flag: set wins.
  - Ack/Nak capture on the accept edge of an Ack/Nak: the new request stays pending.
- Leaving DL_Active, at any time including mid-SEND:
  - On the next edge, drop valid, go to IDLE, and clear all pending flags and the timer.
  - Last-sent credits are retained.
- Reset mid-SEND: outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package dll_pkg holds:
  - the DLC state encodings (DLC_DL_ACTIVE = 2'b11);
  - DLLP type byte constants (DLLP_ACK, DLLP_NAK, DLLP_UPDFC_P/NP/CPL);
  - the fc_type_e enum {FC_P, FC_NP, FC_CPL};
  - the DLLP bus width constant (136).
- One sub-module: dll_rr_arb3, a 3-request round-robin arbiter with a one-hot grant and a pointer update on an accept strobe.

Test Plan:
- Enter DL_Active, credits P=8'h10/12'h040, NP=8'h08/12'h000, Cpl=8'h00/12'h000, ready=1 → three back-to-back UpdateFCs: P bytes 80 04 00 40, then NP 90 02 00 00, then Cpl A0 00 00 00; valid high for 3 cycles.
- Ack seq=12'h123 while ready=0 and UpdateFC-NP pending → Ack (00 00 01 23) presented first and held stable for 5 stall cycles; NP sent after accept.
- Ack seq 0x010 then Nak seq 0x011 then Ack seq 0x012 within SEND stall → a single Nak with seq 0x011 emitted next.
- No credit change, UPDATE_TIMER=16 → UpdateFC P/NP/Cpl burst every 16 cycles; the round-robin order rotates from the last accepted type.
- Drop dlc_state_i to 2'b01 during SEND with ready=0 → valid=0 on the next cycle. Re-entering Active → all three UpdateFCs resent.
- Assert rst_n=0 mid-SEND → dllp_valid_o=0 and dllp_o=0 asynchronously, before the next clock edge.
